// File: rtl/dtcm_arb_if.sv
// Requester-side bus of the data TCM arbiter: one request channel plus its
// grant and read-response return path. The requester drives through the
// master modport; the arbiter sits on the slave modport.
interface dtcm_arb_if;
    logic        req;
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr, wen, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, wen, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dtcm_arb.sv
// dtcm_arb: two-requester arbiter in front of a single-port 1024x32 data TCM.
// Port C (load/store unit) has priority over port D (DMA/debug). The TCM
// returns read data one cycle after the address; the arbiter remembers which
// port issued the read and raises only that port's rvalid.
// Optional build macro DTCM_ARB_AGE_EN: adds an aging counter that forces a
// D grant after D has been refused MAX_WAIT cycles, so D cannot starve.
// Without the macro, C priority is strict. MAX_WAIT is legal in 1..15.
module dtcm_arb #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    dtcm_arb_if.slave   c,
    dtcm_arb_if.slave   d,
    output logic [31:0] m_addr,
    output logic [3:0]  m_wen,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    logic c_gnt;
    logic d_gnt;
    logic force_hit;        // a forced D grant is due this cycle
    logic rsel_c_reg;
    logic rsel_c_next;
    logic rsel_d_reg;
    logic rsel_d_next;

`ifdef DTCM_ARB_AGE_EN
    localparam logic [3:0] MAX_WAIT_CNT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_reg;
    logic [3:0] wait_cnt_next;
    logic       force_d_reg;
    logic       force_d_next;

    // Forcing only matters while D still asks; a dropped request lets C through.
    assign force_hit = force_d_reg && d.req;

    // Aging: count refused D cycles, arm the force once the limit is reached.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        force_d_next  = force_d_reg;
        if (d_gnt) begin
            wait_cnt_next = 4'd0;
            force_d_next  = 1'b0;
        end else if (d.req) begin
            if (wait_cnt_reg != MAX_WAIT_CNT) begin
                wait_cnt_next = wait_cnt_reg + 4'd1;
            end else begin
                force_d_next = 1'b1;
            end
        end else if (force_d_reg) begin
            wait_cnt_next = 4'd0;
            force_d_next  = 1'b0;
        end
    end

    // Aging state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= 4'd0;
            force_d_reg  <= 1'b0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            force_d_reg  <= force_d_next;
        end
    end
`else
    assign force_hit = 1'b0;
`endif

    // Grant: C first unless D is being forced through, otherwise D.
    always_comb begin
        c_gnt = c.req && !force_hit;
        d_gnt = d.req && !c_gnt;
    end

    // TCM drive: granted port's request; idle cycles issue a harmless read.
    always_comb begin
        m_addr  = c.addr;
        m_wen   = 4'b0000;
        m_wdata = 32'd0;
        if (c_gnt) begin
            m_wen   = c.wen;
            m_wdata = c.wdata;
        end else if (d_gnt) begin
            m_addr  = d.addr;
            m_wen   = d.wen;
            m_wdata = d.wdata;
        end
    end

    // Response steering: note which port owns next cycle's read data.
    always_comb begin
        rsel_c_next = c_gnt && (c.wen == 4'b0000);
        rsel_d_next = d_gnt && (d.wen == 4'b0000);
    end

    // Response select registers; reset drops any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsel_c_reg <= 1'b0;
            rsel_d_reg <= 1'b0;
        end else begin
            rsel_c_reg <= rsel_c_next;
            rsel_d_reg <= rsel_d_next;
        end
    end

    assign c.gnt    = c_gnt;
    assign d.gnt    = d_gnt;
    assign c.rvalid = rsel_c_reg;
    assign d.rvalid = rsel_d_reg;
    assign c.rdata  = m_rdata;
    assign d.rdata  = m_rdata;

endmodule

// File: doc/dtcm_arb.md
# dtcm_arb

Two-requester arbiter in front of the single-port data TCM (1024×32, byte-write-enabled, registered read data one cycle after address). It shares the TCM between the core load/store unit (port C) and the DMA/debug engine (port D). Each cycle it grants at most one request and drives the TCM port. It routes the next-cycle read data back to the requester that issued the read. Port C has priority; an optional aging counter guarantees forward progress for port D.

## Interface
- `MAX_WAIT`, 8: cycles D may be refused while C is granted before D is forced through; legal 1..15.
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `c_req`  in  1  port C request, valid this cycle.
- `c_addr`  in  32  port C byte address; bits [11:2] select the word.
- `c_wen`  in  4  port C byte write enables; 4'b0000 means read.
- `c_wdata`  in  32  port C write data.
- `c_gnt`  out  1  port C request accepted this cycle (combinational).
- `c_rvalid`  out  1  port C read data valid (registered).
- `c_rdata`  out  32  port C read data.
- `d_req`, `d_addr`, `d_wen`, `d_wdata`, `d_gnt`, `d_rvalid`, `d_rdata`: same meaning and widths for port D.
- `m_addr`  out  32  TCM address.
- `m_wen`  out  4  TCM byte write enables.
- `m_wdata`  out  32  TCM write data.
- `m_rdata`  in  32  TCM read data, valid the cycle after the address.

## Operation
- Grant rule: if `c_req` is high and no forced D grant is pending, grant C. Else, if `d_req` is high, grant D. At most one `*_gnt` is high per cycle; `*_gnt` is never high without its `*_req`.
- Requesters hold `req`, `addr`, `wen` and `wdata` stable until `gnt`. A request is consumed in the cycle `gnt` is high; there is no queueing.
- TCM drive (combinational mux):
  - Granted port's `addr`, `wen` and `wdata` go to `m_*`.
  - With no grant: `m_wen`=0, `m_addr`=`c_addr`, `m_wdata`=0. The resulting read is harmless.
- Response tracking: registers `rsel_c` and `rsel_d` are set the cycle after a granted read (`wen`==0). `c_rvalid`=`rsel_c`, `d_rvalid`=`rsel_d`. No rvalid is generated for writes.
- Read data: `c_rdata` = `d_rdata` = `m_rdata`, unqualified. Requesters must qualify it with their own `rvalid`. There is no backpressure on responses.
- Write then read to the same word on consecutive grants: the read returns the new data, because the TCM write lands at the grant edge.
- Partial write: only the bytes enabled in `wen` change.

## Timing
- Grant: same cycle as `req` (zero latency when uncontended).
- Read latency: `rvalid` rises exactly 1 cycle after `gnt`.
- Throughput: one access per cycle; back-to-back grants to the same or alternating ports are legal.
- Reset values: `rsel_c`=0, `rsel_d`=0 (so `c_rvalid`=`d_rvalid`=0), `wait_cnt`=0, `force_d`=0. Combinational outputs follow their inputs during reset.
- Reset asserted mid-read: the pending `rvalid` is dropped and must not appear after reset release.

## Configuration
- `DTCM_ARB_AGE_EN` defined:
  - 4-bit `wait_cnt` increments each cycle that `d_req` is high and `d_gnt` is low. It saturates at `MAX_WAIT` and clears on `d_gnt`.
  - When `wait_cnt`==`MAX_WAIT`, `force_d` is set. In the next cycle D wins even if `c_req` is high; `force_d` clears on that grant.
  - If `d_req` drops while `force_d` is set, `force_d` and `wait_cnt` clear.
- Not defined: strict C priority. `wait_cnt` and `force_d` are absent, and D can starve indefinitely.

## Test plan
- Reset: assert `rst_n`=0 with `c_req`=1 read pending → `c_rvalid`=`d_rvalid`=0 immediately and on the first cycle after release.
- Uncontended read: C writes 0xDEADBEEF at 0x010 (`wen`=4'hF), then reads 0x010 → `c_gnt`=1 both cycles, `c_rvalid`=1 one cycle after the read grant, `c_rdata`=0xDEADBEEF, `d_rvalid`=0.
- Byte write: D writes 0x000000AA with `wen`=4'b0001 to 0x010 holding 0x11223344, then reads → `d_rdata`=0x112233AA.
- Contention, no macro: `c_req` and `d_req` high for 20 cycles → `c_gnt`=1 every cycle, `d_gnt`=0 throughout.
- Contention, `DTCM_ARB_AGE_EN`, `MAX_WAIT`=8:
  - Same stimulus as the previous scenario.
  - `d_gnt` pulses for one cycle on the 10th contended cycle: counter reaches 8 after 8 refused cycles, `force_d` registers on the 9th, D is granted on the 10th.
  - `c_gnt`=0 in that cycle; the pattern repeats every 10 cycles.
- Interleaved reads: C reads 0x000, D reads 0x004, C reads 0x008 on consecutive grants → each `rvalid` lands on its own port in order with the matching word, and no cycle has both `rvalid`s high.
